// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - 6-digit multiplexed 7-segment driver for clock/stopwatch time fields
// Ports: Clock_5K/Reset (synchronous, active-high); Control picks clock (1) or
// stopwatch (0) layout; Hours/Mins/Secs/MSecs/AM_PM/Alarm are the live time
// inputs; Seg/Dp/DigitEn drive the display (all registered, active-high);
// FrameStart pulses on the guard cycle of digit 5.
module display_scan_driver #(
    parameter int SCAN_DIV  = 5,
    parameter int BLINK_DIV = 2500
) (
    input  logic       Clock_5K,
    input  logic       Reset,
    input  logic       Control,
    input  logic [3:0] Hours,
    input  logic [5:0] Mins,
    input  logic [5:0] Secs,
    input  logic [9:0] MSecs,
    input  logic       AM_PM,
    input  logic       Alarm,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic [5:0] DigitEn,
    output logic       FrameStart
);
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic {S_GUARD, S_DRIVE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [2:0]    idx_q, idx_d;
    logic          run_q, run_d;
    logic          frame_start;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          alarm_prev_q, alarm_prev_d;

    logic          snap_ctl_q, snap_ctl_d;
    logic [3:0]    snap_hours_q, snap_hours_d;
    logic [5:0]    snap_mins_q, snap_mins_d;
    logic [5:0]    snap_secs_q, snap_secs_d;
    logic [9:0]    snap_msecs_q, snap_msecs_d;
    logic          snap_ampm_q, snap_ampm_d;
    logic          snap_alarm_q, snap_alarm_d;
    logic          snap_phase_q, snap_phase_d;

    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [5:0]    digit_en_q, digit_en_d;
    logic          frame_start_q, frame_start_d;

    logic [6:0]    pair_v;
    logic          pair_ok;
    logic [6:0]    cc_v;
    logic [3:0]    tens, units;
    logic [6:0]    seg_pat;
    logic          dp_pat;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Scan sequencing. run_q is clear only straight after reset, so the first
    // live cycle re-enters the digit-5 guard slot as a frame start.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        idx_d       = idx_q;
        run_d       = 1'b1;
        frame_start = 1'b0;
        if (!run_q) begin
            state_d     = S_GUARD;
            slot_d      = '0;
            idx_d       = 3'd5;
            frame_start = 1'b1;
        end else begin
            case (state_q)
                S_GUARD: begin
                    state_d = S_DRIVE;
                    slot_d  = slot_q + 1'b1;
                end
                default: begin
                    if (slot_q == SLOT_LAST) begin
                        state_d = S_GUARD;
                        slot_d  = '0;
                        if (idx_q == 3'd0) begin
                            idx_d       = 3'd5;
                            frame_start = 1'b1;
                        end else begin
                            idx_d = idx_q - 3'd1;
                        end
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Blink timebase; a fresh alarm restarts it in the visible phase.
    always_comb begin
        alarm_prev_d = Alarm;
        blink_cnt_d  = blink_cnt_q + 1'b1;
        phase_d      = phase_q;
        if (Alarm && !alarm_prev_q) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    // Whole-frame snapshot taken on the same edge that raises FrameStart.
    always_comb begin
        snap_ctl_d   = frame_start ? Control : snap_ctl_q;
        snap_hours_d = frame_start ? Hours   : snap_hours_q;
        snap_mins_d  = frame_start ? Mins    : snap_mins_q;
        snap_secs_d  = frame_start ? Secs    : snap_secs_q;
        snap_msecs_d = frame_start ? MSecs   : snap_msecs_q;
        snap_ampm_d  = frame_start ? AM_PM   : snap_ampm_q;
        snap_alarm_d = frame_start ? Alarm   : snap_alarm_q;
        snap_phase_d = frame_start ? phase_q : snap_phase_q;
    end

    // Digit decode for the slot being entered. Odd indices carry tens,
    // even indices carry units; idx[2:1] selects the field pair.
    always_comb begin
        cc_v    = 7'(snap_msecs_q / 10'd10);
        pair_v  = {1'b0, snap_secs_q};
        pair_ok = (snap_secs_q <= 6'd59);
        if (snap_ctl_q) begin
            if (idx_d[2:1] == 2'd2) begin
                pair_v  = {3'b000, snap_hours_q};
                pair_ok = (snap_hours_q != 4'd0) && (snap_hours_q <= 4'd12);
            end else if (idx_d[2:1] == 2'd1) begin
                pair_v  = {1'b0, snap_mins_q};
                pair_ok = (snap_mins_q <= 6'd59);
            end
        end else begin
            if (idx_d[2:1] == 2'd2) begin
                pair_v  = {1'b0, snap_mins_q};
                pair_ok = (snap_mins_q <= 6'd59);
            end else if (idx_d[2:1] == 2'd1) begin
                pair_v  = {1'b0, snap_secs_q};
                pair_ok = (snap_secs_q <= 6'd59);
            end else begin
                pair_v  = cc_v;
                pair_ok = (snap_msecs_q <= 10'd999);
            end
        end
        tens  = 4'(pair_v / 7'd10);
        units = 4'(pair_v % 7'd10);
        if (!pair_ok) begin
            seg_pat = 7'h40;
        end else if (idx_d[0]) begin
            // Leading hours zero is blanked in clock mode only.
            seg_pat = (snap_ctl_q && idx_d == 3'd5 && tens == 4'd0) ? 7'h00 : seg7(tens);
        end else begin
            seg_pat = seg7(units);
        end
        dp_pat = (idx_d == 3'd4) || (idx_d == 3'd2) ||
                 ((idx_d == 3'd0) && snap_ctl_q && snap_ampm_q);
    end

    always_comb begin
        seg_d         = '0;
        dp_d          = 1'b0;
        digit_en_d    = '0;
        frame_start_d = frame_start;
        if (state_d == S_DRIVE) begin
            digit_en_d = 6'b000001 << idx_d;
            if (!(snap_alarm_q && !snap_phase_q)) begin
                seg_d = seg_pat;
                dp_d  = dp_pat;
            end
        end
    end

    always_ff @(posedge Clock_5K) begin
        if (Reset) begin
            state_q       <= S_GUARD;
            slot_q        <= '0;
            idx_q         <= 3'd5;
            run_q         <= 1'b0;
            blink_cnt_q   <= '0;
            phase_q       <= 1'b1;
            alarm_prev_q  <= 1'b0;
            snap_ctl_q    <= 1'b0;
            snap_hours_q  <= '0;
            snap_mins_q   <= '0;
            snap_secs_q   <= '0;
            snap_msecs_q  <= '0;
            snap_ampm_q   <= 1'b0;
            snap_alarm_q  <= 1'b0;
            snap_phase_q  <= 1'b0;
            seg_q         <= '0;
            dp_q          <= 1'b0;
            digit_en_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            run_q         <= run_d;
            blink_cnt_q   <= blink_cnt_d;
            phase_q       <= phase_d;
            alarm_prev_q  <= alarm_prev_d;
            snap_ctl_q    <= snap_ctl_d;
            snap_hours_q  <= snap_hours_d;
            snap_mins_q   <= snap_mins_d;
            snap_secs_q   <= snap_secs_d;
            snap_msecs_q  <= snap_msecs_d;
            snap_ampm_q   <= snap_ampm_d;
            snap_alarm_q  <= snap_alarm_d;
            snap_phase_q  <= snap_phase_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            digit_en_q    <= digit_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign Seg        = seg_q;
    assign Dp         = dp_q;
    assign DigitEn    = digit_en_q;
    assign FrameStart = frame_start_q;
endmodule

// File: tb/tb_display_scan_driver.sv
// tb/tb_display_scan_driver.sv - scoreboard bench for display_scan_driver
module tb_display_scan_driver;
    localparam int BD    = 10;
    localparam int SD    = 5;
    localparam int FRAME = 6 * SD;

    logic       clk = 1'b0;
    logic       rst, ctl, ampm, alarm;
    logic [3:0] hours;
    logic [5:0] mins, secs;
    logic [9:0] msecs;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] digit_en;
    logic       frame_start;

    always #5 clk = ~clk;

    display_scan_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .Clock_5K(clk), .Reset(rst), .Control(ctl), .Hours(hours), .Mins(mins),
        .Secs(secs), .MSecs(msecs), .AM_PM(ampm), .Alarm(alarm),
        .Seg(seg), .Dp(dp), .DigitEn(digit_en), .FrameStart(frame_start)
    );

    typedef struct packed {
        logic [5:0][6:0] seg;
        logic [5:0]      dp;
    } frame_t;

    frame_t exp_q[$];
    int     checks = 0;
    int     failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Expected frame from field values: three (value, valid) pairs left to right.
    function automatic frame_t build(input logic c, input int h, input int mi, input int s,
                                     input int ms, input logic ap, input logic al, input logic ph);
        frame_t f;
        int     v[3];
        bit     ok[3];
        if (c) begin
            v  = '{h, mi, s};
            ok = '{(h >= 1 && h <= 12), (mi <= 59), (s <= 59)};
        end else begin
            v  = '{mi, s, ms / 10};
            ok = '{(mi <= 59), (s <= 59), (ms <= 999)};
        end
        for (int p = 0; p < 3; p++) begin
            if (!ok[p]) begin
                f.seg[5 - 2*p] = 7'h40;
                f.seg[4 - 2*p] = 7'h40;
            end else begin
                f.seg[5 - 2*p] = (c && p == 0 && v[p] < 10) ? 7'h00 : seg_of(v[p] / 10);
                f.seg[4 - 2*p] = seg_of(v[p] % 10);
            end
        end
        f.dp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, c & ap};
        if (al && !ph) begin
            f.seg = '0;
            f.dp  = '0;
        end
        return f;
    endfunction

    // Reference model: frame timing counted in cycles from reset release,
    // blink phase from cycles elapsed since the last reset or alarm rise.
    logic in_rst_s = 1'b1;
    int   since_anchor = 0;
    logic prev_alarm = 1'b0;
    bit   started = 0;
    int   cyc = 0;

    always @(posedge clk) begin : model
        bit fs;
        fs = 0;
        if (rst) begin
            in_rst_s     = 1'b1;
            started      = 0;
            since_anchor = 0;
            prev_alarm   = 1'b0;
        end else begin
            in_rst_s = 1'b0;
            if (!started) begin
                started = 1;
                cyc     = 0;
                fs      = 1;
            end else begin
                cyc++;
                if (cyc == FRAME) begin
                    cyc = 0;
                    fs  = 1;
                end
            end
            if (fs)
                exp_q.push_back(build(ctl, int'(hours), int'(mins), int'(secs), int'(msecs),
                                      ampm, alarm, ((since_anchor / BD) % 2) == 0));
            if (alarm && !prev_alarm) since_anchor = 0;
            else                      since_anchor++;
            prev_alarm = alarm;
        end
    end

    // Monitor: pops one expected frame per FrameStart and checks each cycle.
    int     pos = -1;
    frame_t cur;
    bit     have = 0;

    always @(negedge clk) begin : monitor
        int         slot, dig;
        logic [5:0] exp_en;
        logic       exp_fs;
        if (in_rst_s) begin
            chk("reset_seg", seg, 0);
            chk("reset_digit_en", digit_en, 0);
            chk("reset_dp", dp, 0);
            chk("reset_frame_start", frame_start, 0);
            exp_q.delete();
            pos  = -1;
            have = 0;
        end else begin
            exp_fs = (pos == -1) || (pos == FRAME - 1);
            chk("frame_start", frame_start, exp_fs);
            if (frame_start) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 1, 0);
                end else begin
                    cur  = exp_q.pop_front();
                    have = 1;
                end
                pos = 0;
            end else if (pos >= 0) begin
                pos++;
                if (pos >= FRAME) pos = 0;
            end
            if (pos >= 0) begin
                slot   = pos % SD;
                dig    = 5 - pos / SD;
                exp_en = (slot == 0) ? 6'd0 : (6'd1 << dig);
                chk("digit_en", digit_en, exp_en);
                if (have) begin
                    chk($sformatf("seg_d%0d", dig), seg, (slot == 0) ? 7'h00 : cur.seg[dig]);
                    chk($sformatf("dp_d%0d", dig), dp, (slot == 0) ? 1'b0 : cur.dp[dig]);
                end
            end
        end
    end

    task automatic set_in(input logic c, input int h, input int mi, input int s,
                          input int ms, input logic ap);
        ctl   = c;
        hours = 4'(h);
        mins  = 6'(mi);
        secs  = 6'(s);
        msecs = 10'(ms);
        ampm  = ap;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        alarm = 1'b0;
        set_in(1, 12, 0, 0, 0, 0);
        hold(3);
        rst = 1'b0;

        set_in(1, 11, 59, 52, 0, 1);
        hold(70);
        set_in(1, 3, 7, 64, 0, 0);
        hold(70);
        set_in(0, 1, 40, 5, 987, 0);
        hold(70);

        // Seconds change inside the D3 slot must not tear the current frame.
        set_in(1, 11, 59, 52, 0, 1);
        hold(40);
        for (int i = 0; i < 40 && pos != 12; i++) @(negedge clk);
        chk("d3_slot_reached", pos, 12);
        secs = 6'd53;
        hold(70);

        alarm = 1'b1;
        hold(200);
        alarm = 1'b0;
        hold(70);

        // Mid-frame reset.
        hold(13);
        rst = 1'b1;
        hold(2);
        rst = 1'b0;
        hold(40);

        for (int it = 0; it < 150; it++) begin
            set_in(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                   int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 5) == 0) alarm = ~alarm;
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                hold(int'($urandom_range(1, 2)));
                rst = 1'b0;
            end
            hold(int'($urandom_range(1, 40)));
        end
        hold(35);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
